// File: rtl/sdram_io_phy_if.sv
// sdram_io_phy_if: controller-side bus of the SDRAM pad PHY.
//   master : SDRAM controller (drives command/address/write data, conflict_clr)
//   slave  : sdram_io_phy    (returns rd_data/rd_valid and the bus_conflict flag)
// Signals: sdram_cs (active-low), sdram_bank, sdram_addr, sdram_ras/cas/we (active-low),
//          sdram_data_out, sdram_drive_data, rd_data, rd_valid, bus_conflict, conflict_clr.
interface sdram_io_phy_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int CS_W   = 1
);
  logic [CS_W-1:0]   sdram_cs;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_ras;
  logic              sdram_cas;
  logic              sdram_we;
  logic [DATA_W-1:0] sdram_data_out;
  logic              sdram_drive_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              bus_conflict;
  logic              conflict_clr;

  modport master (
    output sdram_cs, sdram_bank, sdram_addr, sdram_ras, sdram_cas, sdram_we,
           sdram_data_out, sdram_drive_data, conflict_clr,
    input  rd_data, rd_valid, bus_conflict
  );

  modport slave (
    input  sdram_cs, sdram_bank, sdram_addr, sdram_ras, sdram_cas, sdram_we,
           sdram_data_out, sdram_drive_data, conflict_clr,
    output rd_data, rd_valid, bus_conflict
  );
endinterface

// File: rtl/sdram_io_phy.sv
// sdram_io_phy: registered SDRAM pad-side PHY.
//   clk, rst_n (synchronous, active-low)
//   ctl        : sdram_io_phy_if.slave, controller-side command/data bus
//   pad_clk    : forwarded clk
//   pad_cs/bank/addr/ras/cas/we : command/address retimed by one clock
//   pad_dq_out, pad_dq_oe : registered DQ drive value and per-bit enable
//   pad_dq_in  : DQ value from the pads
// A READ opens a capture window CAS_LAT+1 clocks after it is presented; the window
// lasts BURST_LEN cycles, and a newer READ restarts it. Write drive that would
// collide with an open window is suppressed and latches the sticky bus_conflict.
// Optional macro SDRAM_PHY_IN_REG_EN: adds an input flop on pad_dq_in, delaying
// capture and rd_valid by one clock (conflict check still uses the pad-side window).
module sdram_io_phy #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int BANK_W    = 2,
  parameter int CS_W      = 1,
  parameter int CAS_LAT   = 2,
  parameter int BURST_LEN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sdram_io_phy_if.slave     ctl,
  output logic              pad_clk,
  output logic [CS_W-1:0]   pad_cs,
  output logic [BANK_W-1:0] pad_bank,
  output logic [ADDR_W-1:0] pad_addr,
  output logic              pad_ras,
  output logic              pad_cas,
  output logic              pad_we,
  output logic [DATA_W-1:0] pad_dq_out,
  output logic [DATA_W-1:0] pad_dq_oe,
  input  logic [DATA_W-1:0] pad_dq_in
);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CS_W-1:0]   cs_q;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ras_q, cas_q, we_q;
  logic [DATA_W-1:0] dq_out_q;
  logic [DATA_W-1:0] dq_oe_q, dq_oe_d;
  logic              drive_q;
  logic [CAS_LAT:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              conflict_q, conflict_d;

  logic              read_dec, win_start, win_open, win_next;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;

`ifdef SDRAM_PHY_IN_REG_EN
  logic [DATA_W-1:0] dq_in_q;
  logic              win_dly_q;
`endif

  assign pad_clk = clk;

  always_comb begin
    read_dec  = (~&ctl.sdram_cs) & ctl.sdram_ras & ~ctl.sdram_cas & ctl.sdram_we;
    sr_d      = {sr_q[CAS_LAT-1:0], read_dec};
    win_start = sr_q[CAS_LAT];
    win_open  = win_start | (cnt_q != '0);
    cnt_d     = '0;
    if (win_start)         cnt_d = CNT_W'(BURST_LEN - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
    // Window state one clock ahead, so the gated output enable stays a pure flop.
    win_next  = sr_q[CAS_LAT-1] | (cnt_d != '0);
    dq_oe_d   = {DATA_W{ctl.sdram_drive_data & ~win_next}};

    conflict_d = conflict_q;
    if (drive_q & win_open)     conflict_d = 1'b1;
    else if (ctl.conflict_clr)  conflict_d = 1'b0;

`ifdef SDRAM_PHY_IN_REG_EN
    cap_en   = win_dly_q;
    cap_data = dq_in_q;
`else
    cap_en   = win_open;
    cap_data = pad_dq_in;
`endif
    rd_valid_d = cap_en;
    rd_data_d  = cap_en ? cap_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q       <= '1;
      bank_q     <= '0;
      addr_q     <= '0;
      ras_q      <= 1'b1;
      cas_q      <= 1'b1;
      we_q       <= 1'b1;
      dq_out_q   <= '0;
      dq_oe_q    <= '0;
      drive_q    <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cs_q       <= ctl.sdram_cs;
      bank_q     <= ctl.sdram_bank;
      addr_q     <= ctl.sdram_addr;
      ras_q      <= ctl.sdram_ras;
      cas_q      <= ctl.sdram_cas;
      we_q       <= ctl.sdram_we;
      dq_out_q   <= ctl.sdram_data_out;
      dq_oe_q    <= dq_oe_d;
      drive_q    <= ctl.sdram_drive_data;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef SDRAM_PHY_IN_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dq_in_q   <= '0;
      win_dly_q <= 1'b0;
    end else begin
      dq_in_q   <= pad_dq_in;
      win_dly_q <= win_open;
    end
  end
`endif

  assign pad_cs           = cs_q;
  assign pad_bank         = bank_q;
  assign pad_addr         = addr_q;
  assign pad_ras          = ras_q;
  assign pad_cas          = cas_q;
  assign pad_we           = we_q;
  assign pad_dq_out       = dq_out_q;
  assign pad_dq_oe        = dq_oe_q;
  assign ctl.rd_data      = rd_data_q;
  assign ctl.rd_valid     = rd_valid_q;
  assign ctl.bus_conflict = conflict_q;
endmodule
